icache_refill_ctrl: RTL

//  Direct-mapped instruction cache controller between the IF stage and a slower backing instruction memory.

---
 rtl/icache_refill_ctrl.sv | 111 +++++++++++
 1 files changed

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: direct-mapped instruction cache that serves hits in the same cycle and refills a whole line over a req/ack handshake
// Ports: clk_i/rst_i (sync, active-high); fetch_req_i/pc_i/flush_i from IF;
//        instr_o/instr_valid_o/stall_o to IF; mem_req_o/mem_addr_o/mem_ack_i/mem_rdata_i to backing memory.
module icache_refill_ctrl #(
    parameter int          LINE_WORDS = 4,
    parameter int          NUM_LINES  = 64,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_req_i,
    input  logic [31:0] pc_i,
    input  logic        flush_i,
    output logic [31:0] instr_o,
    output logic        instr_valid_o,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 32 - IDX_W - OFF_W - 2;
    localparam int LN_W  = 32 - OFF_W - 2;

    typedef enum logic [1:0] {IDLE, REFILL, FILL_DONE} state_t;

    state_t               state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;
    logic [OFF_W-1:0]     cnt_q, cnt_d;
    logic [LN_W-1:0]      line_q, line_d;
    logic                 flush_pend_q, flush_pend_d;

    logic [TAG_W-1:0] tag_q  [NUM_LINES];
    logic [31:0]      data_q [NUM_LINES*LINE_WORDS];

    logic [OFF_W-1:0] pc_off;
    logic [IDX_W-1:0] pc_idx, fill_idx;
    logic [TAG_W-1:0] pc_tag, fill_tag;
    logic             hit, last, wr_word, unused_pc;

    assign pc_off    = pc_i[OFF_W+1:2];
    assign pc_idx    = pc_i[IDX_W+OFF_W+1:OFF_W+2];
    assign pc_tag    = pc_i[31:IDX_W+OFF_W+2];
    assign unused_pc = ^pc_i[1:0];
    // The line being refilled is addressed from the latched base, not pc_i.
    assign fill_idx  = line_q[IDX_W-1:0];
    assign fill_tag  = line_q[LN_W-1:IDX_W];
    assign hit       = valid_q[pc_idx] && tag_q[pc_idx] == pc_tag;
    assign last      = cnt_q == OFF_W'(LINE_WORDS-1);
    assign wr_word   = state_q == REFILL && mem_ack_i;

    assign instr_valid_o = state_q == IDLE && fetch_req_i && hit && !flush_i;
    assign instr_o       = instr_valid_o ? data_q[{pc_idx, pc_off}] : NOP_INSTR;
    assign stall_o       = fetch_req_i && !instr_valid_o;
    assign mem_req_o     = state_q == REFILL;
    assign mem_addr_o    = mem_req_o ? {line_q, cnt_q, 2'b00} : '0;

    always_comb begin
        state_d      = state_q;
        valid_d      = flush_i ? '0 : valid_q;
        cnt_d        = cnt_q;
        line_d       = line_q;
        flush_pend_d = flush_pend_q;
        if (state_q == IDLE) begin
            if (fetch_req_i && !hit && !flush_i) begin
                state_d = REFILL;
                line_d  = pc_i[31:OFF_W+2];
                cnt_d   = '0;
            end
        end else if (state_q == REFILL) begin
            // A flush never aborts the handshake; it only keeps this line from becoming valid.
            flush_pend_d = flush_pend_q || flush_i;
            if (mem_ack_i) begin
                if (last) begin
                    state_d      = FILL_DONE;
                    flush_pend_d = 1'b0;
                    if (!flush_i && !flush_pend_q) valid_d[fill_idx] = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end else begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            cnt_q        <= '0;
            line_q       <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            cnt_q        <= cnt_d;
            line_q       <= line_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_word) begin
            data_q[{fill_idx, cnt_q}] <= mem_rdata_i;
            if (last) tag_q[fill_idx] <= fill_tag;
        end
    end
endmodule
